imm_decode_queue: RTL and testbench
===================================

// Module: imm_decode_queue
// PURPOSE
//  Decode-side instruction queue with integrated immediate generation. Each accepted
//  instruction has its XLEN-wide immediate and format code computed at enqueue and stored
//  with it. Entries leave in order through a valid/ready port toward the ID/EX boundary.
//  Replaces the single-cycle combinational immediate path; adds XLEN scaling, buffering,
//  flush and illegal-opcode flagging.
// PARAMETERS
//  XLEN   32  datapath width; legal values 32 or 64; immediates sign/zero-extend to XLEN
//  DEPTH  4   queue entries; power of two, >=2
// PORTS
//  clk        in   1     clock, rising edge
//  rst        in   1     asynchronous reset, active-high
//  flush      in   1     discard all entries (branch mispredict / trap)
//  in_valid   in   1     instr/pc valid
//  in_ready   out  1     queue can accept; = !full
//  in_instr   in   32    raw instruction
//  in_pc      in   XLEN  instruction address
//  out_valid  out  1     head entry valid; = !empty
//  out_ready  in   1     consumer takes head this cycle
//  out_instr  out  32    head instruction
//  out_pc     out  XLEN  head pc
//  out_imm    out  XLEN  head immediate
//  out_fmt    out  3     0=none 1=I 2=S 3=B 4=U 5=J 6=SHAMT 7=CSR-zimm
//  out_illegal out 1     head opcode unrecognised
// BEHAVIOUR
//  - rst: queue empty, pointers/count 0; in_ready=1, out_valid=0; out_* data 0.
//  - Push when in_valid&in_ready; pop when out_valid&out_ready. No full->empty bypass:
//    write-to-out_valid latency is 1 cycle; in_ready depends on registered count only.
//  - Push+pop same cycle (neither full nor empty): both occur, count unchanged.
//    When full: in_ready=0, pop proceeds, push refused. When empty: pop ignored.
//  - flush has priority: next cycle count=0, out_valid=0, any same-cycle push is dropped.
//  - Pointers wrap modulo DEPTH; count range 0..DEPTH.
//  - out_* driven from head entry registers; stable while out_valid&!out_ready.
//  - Immediate decode by opcode[6:0]:
//    0000011,1100111,0010011(non-shift),0011011(non-shift, XLEN=64) -> I: sext(ins[31:20])
//    0010011 funct3 001/101 -> SHAMT: zext(ins[24:20]) XLEN=32; zext(ins[25:20]) XLEN=64
//    0011011 funct3 001/101 (XLEN=64) -> SHAMT zext(ins[24:20])
//    0100011 -> S: sext({ins[31:25],ins[11:7]})
//    1100011 -> B: sext({ins[31],ins[7],ins[30:25],ins[11:8],1'b0})
//    0110111,0010111 -> U: sext({ins[31:12],12'b0})
//    1101111 -> J: sext({ins[31],ins[19:12],ins[20],ins[30:21],1'b0})
//    1110011 funct3[2]=1 -> CSR: zext(ins[19:15]); funct3[2]=0 -> fmt none, imm 0
//    0110011,0111011(XLEN=64),0001111 -> fmt none, imm 0, legal
//    anything else (incl. 0011011 at XLEN=32) -> imm 0, fmt 0, illegal=1. Never X.
//  - Reset asserted mid-operation: all entries lost immediately, outputs to reset values.
// CONFIGURATION
//  IMM_TARGET_PRECALC_EN defined: extra output out_target (XLEN) = out_pc + out_imm
//    (mod 2^XLEN), computed at enqueue and stored, valid for B/J; 0 for all other fmts;
//    reset 0. Not defined: port and storage absent; all other behaviour identical.
// TESTING
//  1 XLEN=32: push 0xFFF00093 (addi -1) -> next cycle out_valid=1, imm 0xFFFFFFFF, fmt 1
//  2 push 0x4030D093 (srai 3) -> imm 0x00000003, fmt 6; 0x01F09093 (slli 31) -> 0x1F
//  3 push 0xFE000EE3 pc 0x100 -> imm 0xFFFFFFFC fmt 3; with _EN out_target 0x000000FC
//  4 push 0x123450B7, 0x0080006F, 0x00000007 -> imm 0x12345000/fmt 4, 8/fmt 5, illegal=1
//  5 DEPTH=4, out_ready=0, push 5 -> in_ready=0 after 4th, 5th refused; then push+pop
//    while full -> pop only; order preserved across pointer wrap over 10 entries
//  6 flush with 3 entries + in_valid -> next cycle out_valid=0, count 0; rst mid-stream
//    same; XLEN=64 addi -1 -> 0xFFFFFFFFFFFFFFFF, slli 63 (0x03F09093) -> 0x3F

Source files
------------

// File: rtl/imm_decode_queue.sv
// In-order decode queue that computes each instruction's immediate, format code and
// illegal flag at enqueue. Optional out_target port enabled by IMM_TARGET_PRECALC_EN.
module imm_decode_queue #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic            out_illegal
`ifdef IMM_TARGET_PRECALC_EN
    ,
    output logic [XLEN-1:0] out_target
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [2:0] FMT_NONE  = 3'd0;
    localparam logic [2:0] FMT_I     = 3'd1;
    localparam logic [2:0] FMT_S     = 3'd2;
    localparam logic [2:0] FMT_B     = 3'd3;
    localparam logic [2:0] FMT_U     = 3'd4;
    localparam logic [2:0] FMT_J     = 3'd5;
    localparam logic [2:0] FMT_SHAMT = 3'd6;
    localparam logic [2:0] FMT_CSR   = 3'd7;

    typedef struct packed {
        logic            illegal;
        logic [2:0]      fmt;
        logic [XLEN-1:0] imm;
    } dec_t;

    function automatic dec_t decode(input logic [31:0] ins);
        dec_t       d;
        logic       is_shift;
        d        = '0;
        is_shift = (ins[14:12] == 3'b001) || (ins[14:12] == 3'b101);
        case (ins[6:0])
            7'b0000011, 7'b1100111: begin
                d.fmt = FMT_I;
                d.imm = XLEN'($signed(ins[31:20]));
            end
            7'b0010011: begin
                if (is_shift) begin
                    d.fmt = FMT_SHAMT;
                    d.imm = (XLEN == 64) ? XLEN'(ins[25:20]) : XLEN'(ins[24:20]);
                end else begin
                    d.fmt = FMT_I;
                    d.imm = XLEN'($signed(ins[31:20]));
                end
            end
            // Word-sized OP-IMM only exists on the 64-bit datapath.
            7'b0011011: begin
                if (XLEN != 64) begin
                    d.illegal = 1'b1;
                end else if (is_shift) begin
                    d.fmt = FMT_SHAMT;
                    d.imm = XLEN'(ins[24:20]);
                end else begin
                    d.fmt = FMT_I;
                    d.imm = XLEN'($signed(ins[31:20]));
                end
            end
            7'b0100011: begin
                d.fmt = FMT_S;
                d.imm = XLEN'($signed({ins[31:25], ins[11:7]}));
            end
            7'b1100011: begin
                d.fmt = FMT_B;
                d.imm = XLEN'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
            end
            7'b0110111, 7'b0010111: begin
                d.fmt = FMT_U;
                d.imm = XLEN'($signed({ins[31:12], 12'b0}));
            end
            7'b1101111: begin
                d.fmt = FMT_J;
                d.imm = XLEN'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
            end
            7'b1110011: begin
                if (ins[14]) begin
                    d.fmt = FMT_CSR;
                    d.imm = XLEN'(ins[19:15]);
                end else begin
                    d.fmt = FMT_NONE;
                end
            end
            7'b0110011, 7'b0001111: d.fmt = FMT_NONE;
            7'b0111011: d.illegal = (XLEN != 64);
            default:    d.illegal = 1'b1;
        endcase
        return d;
    endfunction

    logic [31:0]     instr_q [DEPTH];
    logic [XLEN-1:0] pc_q    [DEPTH];
    logic [XLEN-1:0] imm_q   [DEPTH];
    logic [2:0]      fmt_q   [DEPTH];
    logic            ill_q   [DEPTH];
`ifdef IMM_TARGET_PRECALC_EN
    logic [XLEN-1:0] tgt_q   [DEPTH];
`endif

    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_s, pop_s;
    dec_t          dec_s;

    assign in_ready    = (count_q != CW'(DEPTH));
    assign out_valid   = (count_q != CW'(0));
    assign push_s      = in_valid && in_ready;
    assign pop_s       = out_valid && out_ready;
    assign dec_s       = decode(in_instr);

    assign out_instr   = instr_q[rd_ptr_q];
    assign out_pc      = pc_q[rd_ptr_q];
    assign out_imm     = imm_q[rd_ptr_q];
    assign out_fmt     = fmt_q[rd_ptr_q];
    assign out_illegal = ill_q[rd_ptr_q];
`ifdef IMM_TARGET_PRECALC_EN
    assign out_target  = tgt_q[rd_ptr_q];
`endif

    // Pointer and occupancy next-state; flush overrides any push or pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control and entry storage; entries are written with their decode at enqueue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                instr_q[i] <= '0;
                pc_q[i]    <= '0;
                imm_q[i]   <= '0;
                fmt_q[i]   <= '0;
                ill_q[i]   <= 1'b0;
`ifdef IMM_TARGET_PRECALC_EN
                tgt_q[i]   <= '0;
`endif
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push_s && !flush) begin
                instr_q[wr_ptr_q] <= in_instr;
                pc_q[wr_ptr_q]    <= in_pc;
                imm_q[wr_ptr_q]   <= dec_s.imm;
                fmt_q[wr_ptr_q]   <= dec_s.fmt;
                ill_q[wr_ptr_q]   <= dec_s.illegal;
`ifdef IMM_TARGET_PRECALC_EN
                tgt_q[wr_ptr_q]   <= ((dec_s.fmt == FMT_B) || (dec_s.fmt == FMT_J)) ?
                                     (in_pc + dec_s.imm) : '0;
`endif
            end
        end
    end
endmodule

// File: tb/tb_imm_decode_queue.sv
// Scoreboard bench for imm_decode_queue: XLEN=32 instance for queue behaviour and decode,
// plus a small XLEN=64 instance for wide immediates.
module tb_imm_decode_queue;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, flush, in_valid, in_ready, out_valid, out_ready, out_illegal;
    logic [31:0] in_instr, in_pc, out_instr, out_pc, out_imm;
    logic [2:0]  out_fmt;
`ifdef IMM_TARGET_PRECALC_EN
    logic [31:0] out_target;
`endif

    logic        in_valid64, in_ready64, out_valid64, out_ready64, out_illegal64;
    logic [31:0] in_instr64, out_instr64;
    logic [63:0] in_pc64, out_pc64, out_imm64;
    logic [2:0]  out_fmt64;
`ifdef IMM_TARGET_PRECALC_EN
    logic [63:0] out_target64;
`endif

    imm_decode_queue #(.XLEN(32), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_pc(out_pc), .out_imm(out_imm), .out_fmt(out_fmt), .out_illegal(out_illegal)
`ifdef IMM_TARGET_PRECALC_EN
        , .out_target(out_target)
`endif
    );

    imm_decode_queue #(.XLEN(64), .DEPTH(DEPTH)) dut64 (
        .clk(clk), .rst(rst), .flush(1'b0),
        .in_valid(in_valid64), .in_ready(in_ready64), .in_instr(in_instr64), .in_pc(in_pc64),
        .out_valid(out_valid64), .out_ready(out_ready64), .out_instr(out_instr64),
        .out_pc(out_pc64), .out_imm(out_imm64), .out_fmt(out_fmt64), .out_illegal(out_illegal64)
`ifdef IMM_TARGET_PRECALC_EN
        , .out_target(out_target64)
`endif
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [2:0]  fmt;
        logic        ill;
        logic [31:0] tgt;
    } exp_t;

    exp_t sb[$];
    exp_t nxt;
    int   total = 0;
    int   bad   = 0;

    // One clock: check handshake flags against the model, score pops, record accepted pushes.
    task automatic tick();
        exp_t e;
        logic mv, mr;
        @(negedge clk);
        mv = (sb.size() != 0);
        mr = (sb.size() < DEPTH);
        total++;
        if (out_valid !== mv) begin bad++; $display("FAIL out_valid got=%0b exp=%0b", out_valid, mv); end
        total++;
        if (in_ready !== mr) begin bad++; $display("FAIL in_ready got=%0b exp=%0b", in_ready, mr); end
        if (flush) begin
            sb.delete();
        end else begin
            if (out_ready && mv) begin
                e = sb.pop_front();
                total++;
                if (out_instr !== e.instr) begin bad++; $display("FAIL instr got=%h exp=%h", out_instr, e.instr); end
                total++;
                if (out_pc !== e.pc) begin bad++; $display("FAIL pc got=%h exp=%h", out_pc, e.pc); end
                total++;
                if (out_imm !== e.imm) begin bad++; $display("FAIL imm got=%h exp=%h ins=%h", out_imm, e.imm, e.instr); end
                total++;
                if (out_fmt !== e.fmt) begin bad++; $display("FAIL fmt got=%0d exp=%0d ins=%h", out_fmt, e.fmt, e.instr); end
                total++;
                if (out_illegal !== e.ill) begin bad++; $display("FAIL illegal got=%0b exp=%0b ins=%h", out_illegal, e.ill, e.instr); end
`ifdef IMM_TARGET_PRECALC_EN
                total++;
                if (out_target !== e.tgt) begin bad++; $display("FAIL target got=%h exp=%h", out_target, e.tgt); end
`endif
            end
            if (in_valid && mr) sb.push_back(nxt);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] imm,
                            input logic [2:0] fmt, input logic ill, input logic [31:0] tgt);
        in_valid = 1'b1;
        in_instr = ins;
        in_pc    = pc;
        nxt      = '{ins, pc, imm, fmt, ill, tgt};
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            tick();
            n++;
        end
        total++;
        if (sb.size() != 0) begin bad++; $display("FAIL drain_timeout left=%0d exp=0", sb.size()); end
        tick();
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL reset_flags got v=%0b r=%0b exp v=0 r=1", out_valid, in_ready);
        end
        total++;
        if (out_instr !== 32'h0 || out_pc !== 32'h0 || out_imm !== 32'h0 ||
            out_fmt !== 3'd0 || out_illegal !== 1'b0) begin
            bad++; $display("FAIL reset_data got ins=%h imm=%h fmt=%0d exp 0", out_instr, out_imm, out_fmt);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_decode();
        out_ready = 1'b1;
        push_one(32'hFFF00093, 32'h0,   32'hFFFFFFFF, 3'd1, 1'b0, 32'h0);
        push_one(32'h4030D093, 32'h4,   32'h00000003, 3'd6, 1'b0, 32'h0);
        push_one(32'h01F09093, 32'h8,   32'h0000001F, 3'd6, 1'b0, 32'h0);
        push_one(32'h03F09093, 32'hC,   32'h0000001F, 3'd6, 1'b0, 32'h0);
        push_one(32'hFE000EE3, 32'h100, 32'hFFFFFFFC, 3'd3, 1'b0, 32'h000000FC);
        push_one(32'h123450B7, 32'h104, 32'h12345000, 3'd4, 1'b0, 32'h0);
        push_one(32'h0080006F, 32'h200, 32'h00000008, 3'd5, 1'b0, 32'h00000208);
        push_one(32'h00000007, 32'h204, 32'h00000000, 3'd0, 1'b1, 32'h0);
        push_one(32'hFE112E23, 32'h208, 32'hFFFFFFFC, 3'd2, 1'b0, 32'h0);
        push_one(32'h000AD073, 32'h20C, 32'h00000015, 3'd7, 1'b0, 32'h0);
        push_one(32'h000A9073, 32'h210, 32'h00000000, 3'd0, 1'b0, 32'h0);
        push_one(32'h002081B3, 32'h214, 32'h00000000, 3'd0, 1'b0, 32'h0);
        push_one(32'h0000000F, 32'h218, 32'h00000000, 3'd0, 1'b0, 32'h0);
        push_one(32'h0000001B, 32'h21C, 32'h00000000, 3'd0, 1'b1, 32'h0);
        push_one(32'h80012083, 32'h220, 32'hFFFFF800, 3'd1, 1'b0, 32'h0);
        drain();
    endtask

    task automatic push_filler(input int k);
        logic [11:0] im;
        im = 12'(k * 16 + 1);
        push_one({im, 5'd0, 3'b000, 5'd1, 7'b0010011}, 32'h1000 + 32'(k * 4),
                 32'(k * 16 + 1), 3'd1, 1'b0, 32'h0);
    endtask

    task automatic test_full_wrap();
        int k, guard;
        logic acc;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) push_filler(i);
        total++;
        if (sb.size() != DEPTH || in_ready !== 1'b0) begin
            bad++; $display("FAIL full_refuse got ready=%0b held=%0d exp ready=0 held=4", in_ready, sb.size());
        end
        out_ready = 1'b1;
        push_filler(9);
        out_ready = 1'b0;
        total++;
        if (sb.size() != DEPTH - 1) begin bad++; $display("FAIL full_pushpop held=%0d exp=3", sb.size()); end
        drain();
        k = 0;
        guard = 0;
        while (k < 10 && guard < 200) begin
            out_ready = 1'($urandom_range(0, 1));
            acc = (sb.size() < DEPTH);
            push_filler(20 + k);
            if (acc) k++;
            guard++;
        end
        total++;
        if (k != 10) begin bad++; $display("FAIL wrap_push_timeout got=%0d exp=10", k); end
        drain();
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) push_filler(40 + i);
        flush = 1'b1;
        push_filler(50);
        flush = 1'b0;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL flush_empty got v=%0b r=%0b exp v=0 r=1", out_valid, in_ready);
        end
        tick();
        out_ready = 1'b1;
        push_filler(51);
        drain();
    endtask

    task automatic test_rst_mid();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) push_filler(60 + i);
        #2 rst = 1'b1;
        #1;
        sb.delete();
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_imm !== 32'h0 || out_instr !== 32'h0) begin
            bad++; $display("FAIL rst_mid got v=%0b r=%0b imm=%h exp v=0 r=1 imm=0", out_valid, in_ready, out_imm);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        push_filler(70);
        drain();
    endtask

    task automatic test_xlen64();
        out_ready64 = 1'b0;
        in_valid64  = 1'b1;
        in_instr64  = 32'hFFF00093;
        @(posedge clk); #1;
        total++;
        if (out_valid64 !== 1'b1 || out_imm64 !== 64'hFFFFFFFFFFFFFFFF || out_fmt64 !== 3'd1) begin
            bad++; $display("FAIL x64_addi got v=%0b imm=%h fmt=%0d exp v=1 imm=ffffffffffffffff fmt=1", out_valid64, out_imm64, out_fmt64);
        end
        in_instr64  = 32'h03F09093;
        out_ready64 = 1'b1;
        @(posedge clk); #1;
        total++;
        if (out_imm64 !== 64'h3F || out_fmt64 !== 3'd6) begin
            bad++; $display("FAIL x64_slli got imm=%h fmt=%0d exp imm=3f fmt=6", out_imm64, out_fmt64);
        end
        in_instr64 = 32'h0010009B;
        @(posedge clk); #1;
        total++;
        if (out_imm64 !== 64'h1 || out_fmt64 !== 3'd1 || out_illegal64 !== 1'b0) begin
            bad++; $display("FAIL x64_addiw got imm=%h fmt=%0d ill=%0b exp imm=1 fmt=1 ill=0", out_imm64, out_fmt64, out_illegal64);
        end
        in_valid64 = 1'b0;
        @(posedge clk); #1;
        total++;
        if (out_valid64 !== 1'b0 || in_ready64 !== 1'b1) begin
            bad++; $display("FAIL x64_empty got v=%0b r=%0b exp v=0 r=1", out_valid64, in_ready64);
        end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = 32'h0; in_pc = 32'h0; nxt = '{32'h0, 32'h0, 32'h0, 3'd0, 1'b0, 32'h0};
        in_valid64 = 1'b0; out_ready64 = 1'b0; in_instr64 = 32'h0; in_pc64 = 64'h0;
        test_reset();
        test_decode();
        test_full_wrap();
        test_flush();
        test_rst_mid();
        test_xlen64();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
